dump_fsm_stage: RTL and testbench

Output-side stage of the SHAKE core and the mirror of the input load stage. It takes squeezed rate blocks from the permutation stage and serialises them into W-bit words for the external consumer, using a valid/ready handshake. It tracks the requested output length in bytes, asks for extra squeezes when the length exceeds one rate block, and marks the final, possibly partial, word.

---
 rtl/shake_pkg.sv | 30 +++
 rtl/piso_buffer.sv | 37 +++
 rtl/dump_fsm_stage.sv | 133 +++++++++++++
 tb/tb_dump_fsm_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE output path.
// Rates are kept both in bytes (length accounting) and in 64-bit lanes (word counting).
package shake_pkg;

    typedef enum logic {
        SHAKE128 = 1'b0,
        SHAKE256 = 1'b1
    } shake_mode_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_BLOCK = 2'd1,
        DUMP       = 2'd2
    } dump_state_e;

    localparam int LANE_W         = 64;
    localparam int RATE_BYTES_128 = 168;
    localparam int RATE_BYTES_256 = 136;
    localparam int RATE_WORDS_128 = 21;
    localparam int RATE_WORDS_256 = 17;

    function automatic logic [7:0] rate_bytes(input shake_mode_e m);
        return (m == SHAKE256) ? 8'(RATE_BYTES_256) : 8'(RATE_BYTES_128);
    endfunction

    function automatic logic [4:0] rate_words(input shake_mode_e m);
        return (m == SHAKE256) ? 5'(RATE_WORDS_256) : 5'(RATE_WORDS_128);
    endfunction

endpackage

// File: rtl/piso_buffer.sv
// Parallel-in / serial-out buffer: loads a whole rate block, presents the low word,
// and shifts right by one word per consumed output.
module piso_buffer #(
    parameter int MAX_RATE_BITS = 1344,
    parameter int W             = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     shift,
    input  logic [MAX_RATE_BITS-1:0] din,
    output logic [W-1:0]             dout
);

    logic [MAX_RATE_BITS-1:0] shreg_q;
    logic [MAX_RATE_BITS-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = din;
        end else if (shift) begin
            shreg_d = shreg_q >> W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign dout = shreg_q[W-1:0];

endmodule

// File: rtl/dump_fsm_stage.sv
// Output stage of the SHAKE core: serialises squeezed rate blocks into W-bit words,
// tracks remaining output bytes and requests further squeezes when needed.
module dump_fsm_stage
    import shake_pkg::*;
#(
    parameter int W             = 64,
    parameter int MAX_RATE_BITS = 1344,
    parameter int LEN_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     hdr_ready,
    input  logic [LEN_W-1:0]         out_len_bytes,
    input  logic                     mode,
    input  logic [MAX_RATE_BITS-1:0] state_in,
    input  logic                     output_buffer_ready,
    output logic                     output_buffer_ready_clr,
    output logic                     squeeze_req,
    output logic [W-1:0]             data_out,
    output logic [W/8-1:0]           keep_out,
    output logic                     valid_out,
    output logic                     last_out,
    input  logic                     ready_in
);

    localparam int KW = W / 8;

    dump_state_e      state_q, state_d;
    shake_mode_e      mode_q, mode_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             hdr_ready_q, hdr_ready_d;

    logic             load, shift;
    logic             clr, sq;
    logic [W-1:0]     shreg_word;
    logic [LEN_W-1:0] rate_bytes_w;
    logic [LEN_W-1:0] take;
    logic [KW-1:0]    keep_w;
    logic             last_w;
    logic             in_dump;

    assign rate_bytes_w = LEN_W'(rate_bytes(mode_q));
    assign take         = (rem_q >= LEN_W'(KW)) ? LEN_W'(KW) : rem_q;
    assign keep_w       = (rem_q >= LEN_W'(KW)) ? '1
                        : KW'((KW'(1) << rem_q[$clog2(KW)-1:0]) - KW'(1));
    assign last_w       = (rem_q <= LEN_W'(KW));
    assign in_dump      = (state_q == DUMP);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        clr     = 1'b0;
        sq      = 1'b0;
        case (state_q)
            IDLE: begin
                if (hdr_ready_q && start) begin
                    rem_d  = out_len_bytes;
                    mode_d = shake_mode_e'(mode);
                    if (out_len_bytes != '0) begin
                        state_d = WAIT_BLOCK;
                    end
                end
            end
            WAIT_BLOCK: begin
                if (output_buffer_ready) begin
                    load    = 1'b1;
                    cnt_d   = rate_words(mode_q);
                    clr     = 1'b1;
                    sq      = (rem_q > rate_bytes_w);
                    state_d = DUMP;
                end
            end
            DUMP: begin
                if (ready_in) begin
                    shift = 1'b1;
                    cnt_d = cnt_q - 5'd1;
                    rem_d = rem_q - take;
                    if (last_w) begin
                        state_d = IDLE;
                    end else if (cnt_q == 5'd1) begin
                        state_d = WAIT_BLOCK;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so hdr_ready stays low while reset is held and for the first cycle after.
        hdr_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= SHAKE128;
            rem_q       <= '0;
            cnt_q       <= '0;
            hdr_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            hdr_ready_q <= hdr_ready_d;
        end
    end

    piso_buffer #(
        .MAX_RATE_BITS(MAX_RATE_BITS),
        .W            (W)
    ) u_piso (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .shift(shift),
        .din  (state_in),
        .dout (shreg_word)
    );

    assign hdr_ready               = hdr_ready_q;
    assign output_buffer_ready_clr = clr;
    assign squeeze_req             = sq;
    assign valid_out               = in_dump;
    assign data_out                = in_dump ? shreg_word : '0;
    assign keep_out                = in_dump ? keep_w : '0;
    assign last_out                = in_dump & last_w;

endmodule

// File: tb/tb_dump_fsm_stage.sv
// Self-checking bench for dump_fsm_stage: table of directed messages, randomized
// messages checked against a byte/word-level model, plus a mid-dump reset sequence.
module tb_dump_fsm_stage;
    import shake_pkg::*;

    localparam int W   = 64;
    localparam int MRB = 1344;
    localparam int LW  = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           hdr_ready;
    logic [LW-1:0]  out_len = '0;
    logic           mode = 1'b0;
    logic [MRB-1:0] state_in = '0;
    logic           obr = 1'b0;
    logic           obr_clr;
    logic           squeeze_req;
    logic [W-1:0]   data_out;
    logic [7:0]     keep_out;
    logic           valid_out;
    logic           last_out;
    logic           ready_in = 1'b0;

    dump_fsm_stage #(.W(W), .MAX_RATE_BITS(MRB), .LEN_W(LW)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .hdr_ready              (hdr_ready),
        .out_len_bytes          (out_len),
        .mode                   (mode),
        .state_in               (state_in),
        .output_buffer_ready    (obr),
        .output_buffer_ready_clr(obr_clr),
        .squeeze_req            (squeeze_req),
        .data_out               (data_out),
        .keep_out               (keep_out),
        .valid_out              (valid_out),
        .last_out               (last_out),
        .ready_in               (ready_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] blk [16][21];
    int          res_words, res_clr, res_sq;
    logic [7:0]  res_last_keep;

    typedef struct {
        bit         m;
        int         len;
        int         rmode;
        int         exp_words;
        int         exp_clr;
        int         exp_sq;
        logic [7:0] exp_keep;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [MRB-1:0] pack(input int b);
        logic [MRB-1:0] r;
        r = '0;
        for (int i = 0; i < 21; i++) r[64*i +: 64] = blk[b][i];
        return r;
    endfunction

    // Drive one message end to end; rmode 0=always ready, 1=pattern 1,0,0,1, 2=random.
    task automatic run_msg(input bit m, input int len, input int rmode);
        int rb, rw, nwords, nblk, k, bi, cyc, didx, rem;
        bit stall, done;
        logic [63:0] hd, exp_d;
        logic [7:0]  hk, exp_k;
        logic        hl;
        int pat [4] = '{1, 0, 0, 1};
        rb = m ? 136 : 168;
        rw = m ? 17 : 21;
        nwords = (len + 7) / 8;
        nblk = (len + rb - 1) / rb;
        k = 0; bi = 0; stall = 0; done = 0;
        hd = '0; hk = '0; hl = 1'b0;
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < 21; i++) blk[b][i] = {$urandom, $urandom};
        res_clr = 0; res_sq = 0; res_words = 0; res_last_keep = '0;

        @(negedge clk); #1;
        cyc = 0;
        while (hdr_ready !== 1'b1 && cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("hdr_ready_wait", {63'b0, hdr_ready}, 64'd1);
        start = 1'b1; mode = m; out_len = LW'(len); obr = 1'b0; ready_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 3000) begin
            didx = (bi < nblk) ? bi : 15;
            state_in = pack(didx);
            obr = 1'b1;
            if (rmode == 0) ready_in = 1'b1;
            else if (rmode == 1) ready_in = pat[cyc % 4][0];
            else ready_in = 1'($urandom_range(0, 1));
            #1;
            if (stall) begin
                chk("hold_valid", {63'b0, valid_out}, 64'd1);
                chk("hold_data", data_out, hd);
                chk("hold_keep", {56'b0, keep_out}, {56'b0, hk});
                chk("hold_last", {63'b0, last_out}, {63'b0, hl});
                stall = 0;
            end
            if (obr_clr) begin res_clr++; bi++; end
            if (squeeze_req) res_sq++;
            if (valid_out) begin
                if (ready_in) begin
                    if (k < nwords) begin
                        rem = len - 8 * k;
                        exp_d = blk[k / rw][k % rw];
                        exp_k = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
                        chk("word_data", data_out, exp_d);
                        chk("word_keep", {56'b0, keep_out}, {56'b0, exp_k});
                        chk("word_last", {63'b0, last_out}, {63'b0, (k == nwords - 1)});
                    end else begin
                        checks++; errors++;
                        $display("FAIL extra_word: got word %0d expected only %0d words", k + 1, nwords);
                    end
                    k++;
                    res_last_keep = keep_out;
                end else begin
                    stall = 1; hd = data_out; hk = keep_out; hl = last_out;
                end
            end
            if (k >= nwords && !valid_out && hdr_ready) done = 1;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL msg_timeout: got %0d words expected %0d", k, nwords);
        end
        obr = 1'b0; ready_in = 1'b0;
        res_words = k;
        chk("clr_count", 64'(res_clr), 64'(nblk));
        chk("sq_count", 64'(res_sq), 64'((nblk > 0) ? nblk - 1 : 0));
    endtask

    vec_t vecs [8];

    initial begin
        int k, cyc;
        vecs[0] = '{0, 32,  0, 4,  1, 0, 8'hFF};
        vecs[1] = '{1, 203, 0, 26, 2, 1, 8'h07};
        vecs[2] = '{0, 168, 0, 21, 1, 0, 8'hFF};
        vecs[3] = '{0, 40,  1, 5,  1, 0, 8'hFF};
        vecs[4] = '{0, 0,   0, 0,  0, 0, 8'h00};
        vecs[5] = '{0, 169, 1, 22, 2, 1, 8'h01};
        vecs[6] = '{1, 136, 2, 17, 1, 0, 8'hFF};
        vecs[7] = '{0, 400, 2, 50, 3, 2, 8'hFF};

        #1;
        chk("rst_hdr_ready", {63'b0, hdr_ready}, 64'd0);
        chk("rst_valid", {63'b0, valid_out}, 64'd0);
        chk("rst_last", {63'b0, last_out}, 64'd0);
        chk("rst_keep", {56'b0, keep_out}, 64'd0);
        chk("rst_data", data_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_msg(vecs[v].m, vecs[v].len, vecs[v].rmode);
            chk("tbl_words", 64'(res_words), 64'(vecs[v].exp_words));
            chk("tbl_clr", 64'(res_clr), 64'(vecs[v].exp_clr));
            chk("tbl_sq", 64'(res_sq), 64'(vecs[v].exp_sq));
            chk("tbl_last_keep", {56'b0, res_last_keep}, {56'b0, vecs[v].exp_keep});
            chk("tbl_end_valid", {63'b0, valid_out}, 64'd0);
        end
        #1;
        chk("len0_follow_hdr_ready", {63'b0, hdr_ready}, 64'd1);

        for (int r = 0; r < 20; r++) begin
            run_msg(1'($urandom_range(0, 1)), $urandom_range(1, 700), 2);
        end

        // Reset while the fifth word of a 21-word block is on the bus.
        @(negedge clk);
        for (int i = 0; i < 21; i++) blk[0][i] = {$urandom, $urandom};
        start = 1'b1; mode = 1'b0; out_len = LW'(168);
        @(negedge clk);
        start = 1'b0; obr = 1'b1; state_in = pack(0); ready_in = 1'b1;
        k = 0; cyc = 0;
        while (cyc < 100) begin
            #1;
            if (valid_out && k == 4) break;
            if (valid_out) k++;
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached", 64'(k), 64'd4);
        chk("rst_mid_word5", data_out, blk[0][4]);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {63'b0, valid_out}, 64'd0);
        chk("rst_mid_data", data_out, 64'd0);
        chk("rst_mid_keep", {56'b0, keep_out}, 64'd0);
        chk("rst_mid_last", {63'b0, last_out}, 64'd0);
        chk("rst_mid_hdr", {63'b0, hdr_ready}, 64'd0);
        chk("rst_mid_clr", {63'b0, obr_clr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; obr = 1'b0; ready_in = 1'b0;
        run_msg(1'b0, 16, 0);
        chk("post_rst_words", 64'(res_words), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
